instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_buf.sv | 76 +++++++
 rtl/instr_fetch.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch-buffer depth and the fetch FSM states.
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int FETCH_DEPTH = 4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_buf.sv
// Fetch buffer: circular queue of requested PCs and their instruction words.
// Entries are allocated when a request is accepted and filled in order as responses return.
module fetch_buf
  import cpu_pkg::*;
#(
  parameter  int DEPTH = FETCH_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   unfilled,
  output logic            full,
  output logic            head_ready,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr
);

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    fill_ptr;
  logic [DEPTH-1:0] filled;
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      filled   <= '0;
      count    <= '0;
      unfilled <= '0;
    end else if (clear) begin
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      filled   <= '0;
      count    <= '0;
      unfilled <= '0;
    end else begin
      // Responses are in order, so unfilled entries are always the youngest ones.
      if (alloc) begin
        tail         <= tail + 1'b1;
        filled[tail] <= 1'b0;
      end
      if (fill) begin
        fill_ptr         <= fill_ptr + 1'b1;
        filled[fill_ptr] <= 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count    <= count + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(fill);
    end
  end

  // NOTE: the payload arrays carry no reset; occupancy and the filled bits decide what is visible.
  always_ff @(posedge clk) begin
    if (alloc && !clear) pc_mem[tail] <= alloc_pc;
    if (fill && !clear)  instr_mem[fill_ptr] <= fill_data;
  end

  assign full       = (count == CW'(DEPTH));
  assign head_ready = (count != '0) && filled[head];
  assign head_pc    = pc_mem[head];
  assign head_instr = instr_mem[head];

endmodule : fetch_buf

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues memory requests, buffers responses and hands them to decode.
// On a jump, outstanding responses are counted in drop_cnt and discarded while in DRAIN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            pc_stop,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("instr_fetch: DEPTH must be a power of two and at least 2");
  end

  fetch_state_e    state, state_next;
  logic [CW-1:0]   drop_cnt, drop_next;
  logic [CW-1:0]   count, unfilled;
  logic            full, head_ready;
  logic [XLEN-1:0] head_pc, head_instr;
  logic            accept, fill, pop, resp_take;

  assign imem_req_addr  = pc_in;
  assign imem_req_valid = reset && !flush && !full;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pc_stop        = !reset || (!flush && !accept);

  assign dec_valid = reset && !flush && head_ready;
  assign dec_pc    = dec_valid ? head_pc    : '0;
  assign dec_instr = dec_valid ? head_instr : '0;
  assign pop       = dec_valid && dec_ready;

  // A response belongs to the drain backlog first; only with none pending does it fill an entry.
  assign fill      = imem_resp_valid && !flush && (drop_cnt == '0) && (unfilled != '0);
  assign resp_take = imem_resp_valid && ((drop_cnt != '0) || (unfilled != '0));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    drop_next  = drop_cnt;
    state_next = state;
    unique case (state)
      RUN: begin
        if (flush) drop_next = unfilled - CW'(resp_take);
      end
      DRAIN: begin
        if (flush)                drop_next = drop_cnt + unfilled - CW'(resp_take);
        else if (imem_resp_valid) drop_next = drop_cnt - 1'b1;
      end
    endcase
    state_next = (drop_next != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      drop_cnt <= drop_next;
    end
  end

  fetch_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .alloc      (accept),
    .alloc_pc   (pc_in),
    .fill       (fill),
    .fill_data  (imem_resp_data),
    .pop        (pop),
    .count      (count),
    .unfilled   (unfilled),
    .full       (full),
    .head_ready (head_ready),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

`ifndef SYNTHESIS
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!reset)
    !(imem_resp_valid && (drop_cnt == '0) && (unfilled == '0)))
    else $error("instr_fetch: response with no outstanding request");
`endif

endmodule : instr_fetch
